// File: rtl/ro_pkg.sv
// Shared definitions for the cochlea readout bus receiver: default sizes,
// the event word layout and the slot decoder.
package ro_pkg;

  localparam int N_CH = 19;
  localparam int CH_W = 5;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            pol;
    logic            eve;
  } evt_t;

  // Trailing-zero count of the binary count; an all-zero count is the wrap
  // slot, which belongs to the top channel.
  function automatic logic [7:0] ctz(input logic [31:0] c, input int n);
    logic [7:0] r;
    logic       found;
    r     = 8'(n - 1);
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && !found && c[i]) begin
        r     = 8'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_evt_fifo.sv
// First-word fall-through event FIFO with a registered head and a sticky
// drop-on-full flag; the head holds its last value when the FIFO drains.
module ro_evt_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic          full, empty, pop, do_push, drop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = !empty && ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_next = count;
    if (do_push && !pop)
      count_next = count + 1'b1;
    else if (pop && !do_push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // A push landing on the next head slot bypasses the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_next;
      count    <= count_next;
      valid    <= (count_next != '0);
      overflow <= overflow | drop;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (count_next != '0)
        dout <= (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/ro_demux_rx.sv
// Receiver for the time-multiplexed readout bus: replica gray counter,
// slot decode, negedge bus capture and enqueue into the event FIFO.
module ro_demux_rx import ro_pkg::*; #(
  parameter int N_CH       = ro_pkg::N_CH,
  parameter int CH_W       = ro_pkg::CH_W,
  parameter int FIFO_DEPTH = 4,
  parameter bit EMIT_ALL   = 1'b0
) (
  input  logic            clk_master,
  input  logic            reset,
  input  logic            sync,
  input  logic            ro_eve,
  input  logic            ro_pol_eve,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic [1:0]      evt_data,
  output logic [N_CH-1:0] gray_cnt,
  output logic            overflow
);

  localparam int W = CH_W + 2;

  logic [N_CH-1:0] bin_cnt, bin_next, gray_next;
  logic            started;
  logic [CH_W-1:0] slot;
  logic            cap_eve, cap_pol, cap_valid;
  logic [CH_W-1:0] cap_slot;
  logic            enq_valid;
  logic [W-1:0]    enq_word;
  logic [W-1:0]    head;

  assign bin_next  = sync ? '0 : bin_cnt + 1'b1;
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign slot      = CH_W'(ctz(32'(bin_cnt), N_CH));

  // started is low for the first cycle after reset or sync: no chip edge yet.
  always_ff @(posedge clk_master or posedge reset) begin
    if (reset) begin
      bin_cnt   <= '0;
      gray_cnt  <= '0;
      started   <= 1'b0;
      enq_valid <= 1'b0;
      enq_word  <= '0;
    end else begin
      bin_cnt   <= bin_next;
      gray_cnt  <= gray_next;
      started   <= !sync;
      enq_valid <= cap_valid && (EMIT_ALL || cap_eve);
      enq_word  <= {cap_slot, cap_pol, cap_eve};
    end
  end

  // The chip drives the bus only during the high phase, so sample it at the fall.
  always_ff @(negedge clk_master or posedge reset) begin
    if (reset) begin
      cap_eve   <= 1'b0;
      cap_pol   <= 1'b0;
      cap_slot  <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_eve   <= ro_eve;
      cap_pol   <= ro_pol_eve;
      cap_slot  <= slot;
      cap_valid <= started;
    end
  end

  ro_evt_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_master),
    .rst      (reset),
    .push     (enq_valid),
    .din      (enq_word),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .dout     (head),
    .overflow (overflow)
  );

  assign evt_ch   = head[W-1:2];
  assign evt_data = head[1:0];

endmodule

// File: tb/tb_ro_demux_rx.sv
// Bench for ro_demux_rx: a chip-side gray counter model drives the bus, a
// scoreboard queue holds expected events and negedge monitors compare them.
module tb_ro_demux_rx;

  logic       clk = 1'b0;
  logic       rst, sync, ro_eve, ro_pol_eve, evt_ready, ready_all;
  logic       evt_valid, overflow, valid_all, ovf_all;
  logic [1:0] evt_ch, evt_data, ch_all, data_all;
  logic [3:0] gray_cnt, gray_all;

  always #5 clk = ~clk;

  ro_demux_rx #(.N_CH(4), .CH_W(2), .FIFO_DEPTH(4), .EMIT_ALL(1'b0)) dut (
    .clk_master (clk), .reset (rst), .sync (sync),
    .ro_eve (ro_eve), .ro_pol_eve (ro_pol_eve),
    .evt_valid (evt_valid), .evt_ready (evt_ready),
    .evt_ch (evt_ch), .evt_data (evt_data),
    .gray_cnt (gray_cnt), .overflow (overflow)
  );

  ro_demux_rx #(.N_CH(4), .CH_W(2), .FIFO_DEPTH(4), .EMIT_ALL(1'b1)) dut_all (
    .clk_master (clk), .reset (rst), .sync (sync),
    .ro_eve (ro_eve), .ro_pol_eve (ro_pol_eve),
    .evt_valid (valid_all), .evt_ready (ready_all),
    .evt_ch (ch_all), .evt_data (data_all),
    .gray_cnt (gray_all), .overflow (ovf_all)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // chip model and stimulus controls
  int         chip_cnt = 0;
  bit         live = 0, first = 1;
  bit   [3:0] mask = 4'b0000;
  int         budget = -1;
  int         exp_limit = -1;
  bit         pol_tgl = 0;
  bit         all_en = 0;
  logic       ready_cmd = 1'b1;
  logic       sync_cmd = 1'b0;

  logic [3:0] q_main[$];
  logic [3:0] q_all[$];
  int         log_main[$];
  int         log_all[$];
  int         pops_main = 0;

  int seq [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 3};

  function automatic int tb_ctz(input int c);
    if (c == 0) return 3;
    for (int i = 0; i < 4; i++)
      if (c[i]) return i;
    return 3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end else
      $display("[TB] %s ok: %0h", name, got);
  endtask

  // One master cycle: chip edge at posedge, bus driven in the high phase.
  task automatic cycle();
    int   s;
    logic e, p;
    @(posedge clk);
    if (sync) begin
      chip_cnt = 0; first = 1; live = 1;
    end else begin
      chip_cnt = (chip_cnt + 1) % 16; first = 0;
    end
    #1;
    evt_ready = ready_cmd;
    sync      = sync_cmd;
    if (live && !first) begin
      s = tb_ctz(chip_cnt);
      e = mask[s] && (budget != 0);
      if (e && budget > 0) budget--;
      p = e ? pol_tgl : 1'b0;
      if (e) pol_tgl = ~pol_tgl;
      ro_eve     = e;
      ro_pol_eve = p;
      if (e && exp_limit != 0) begin
        q_main.push_back({s[1:0], p, e});
        if (exp_limit > 0) exp_limit--;
      end
      if (all_en) q_all.push_back({s[1:0], p, e});
    end
    @(negedge clk);
    #1;
    ro_eve     = 1'b0;
    ro_pol_eve = 1'b0;
  endtask

  // Reset released with sync held, so the first edge afterwards aligns the chip.
  task automatic do_reset();
    #2;
    rst = 1'b1; sync = 1'b1; sync_cmd = 1'b0;
    ro_eve = 1'b0; ro_pol_eve = 1'b0;
    evt_ready = ready_cmd;
    live = 0; first = 1; pol_tgl = 0;
    q_main.delete(); q_all.delete(); log_main.delete(); log_all.delete();
    pops_main = 0;
    #20;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon_main
    logic [3:0] e;
    if (!rst && evt_valid && evt_ready) begin
      pops_main++;
      log_main.push_back(int'(evt_ch));
      n_tests++;
      if (q_main.size() == 0) begin
        n_fail++;
        $display("FAIL main_evt: got ch=%0d data=%b, expected none", evt_ch, evt_data);
      end else begin
        e = q_main.pop_front();
        if ({evt_ch, evt_data} !== e) begin
          n_fail++;
          $display("FAIL main_evt: got ch=%0d data=%b, expected ch=%0d data=%b",
                   evt_ch, evt_data, e[3:2], e[1:0]);
        end else
          $display("[TB] main_evt ch=%0d data=%b ok", evt_ch, evt_data);
      end
    end
  end

  always @(negedge clk) begin : mon_all
    logic [3:0] e;
    if (!rst && all_en && valid_all && ready_all) begin
      log_all.push_back(int'(ch_all));
      n_tests++;
      if (q_all.size() == 0) begin
        n_fail++;
        $display("FAIL all_evt: got ch=%0d data=%b, expected none", ch_all, data_all);
      end else begin
        e = q_all.pop_front();
        if ({ch_all, data_all} !== e) begin
          n_fail++;
          $display("FAIL all_evt: got ch=%0d data=%b, expected ch=%0d data=%b",
                   ch_all, data_all, e[3:2], e[1:0]);
        end else
          $display("[TB] all_evt ch=%0d data=%b ok", ch_all, data_all);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [4];
    int mism;
    bit saw_valid;

    rst = 1'b1; sync = 1'b1; ro_eve = 1'b0; ro_pol_eve = 1'b0;
    evt_ready = 1'b1; ready_all = 1'b1;
    #3;
    check("rst_valid",    32'(evt_valid), 0);
    check("rst_ch",       32'(evt_ch),    0);
    check("rst_data",     32'(evt_data),  0);
    check("rst_overflow", 32'(overflow),  0);
    check("rst_gray",     32'(gray_cnt),  0);
    #20;
    rst = 1'b0;

    // channel 0 only: one event every two cycles, 12 over counts 1..23
    mask = 4'b0001;
    repeat (24) cycle();
    check("t1_gray", 32'(gray_cnt), 32'(4'd4));
    mask = 4'b0000;
    repeat (6) cycle();
    check("t1_events",  pops_main,     12);
    check("t1_q_empty", q_main.size(), 0);

    // all channels over one full 16-count period
    do_reset();
    mask = 4'b1111;
    repeat (17) cycle();
    mask = 4'b0000;
    repeat (6) cycle();
    check("t2_events", log_main.size(), 16);
    cnt = '{0, 0, 0, 0};
    mism = 0;
    for (int i = 0; i < log_main.size() && i < 16; i++) begin
      if (log_main[i] != seq[i]) mism++;
      cnt[log_main[i] % 4]++;
    end
    check("t2_seq_mism", mism, 0);
    check("t2_ch0", cnt[0], 8);
    check("t2_ch1", cnt[1], 4);
    check("t2_ch2", cnt[2], 2);
    check("t2_ch3", cnt[3], 2);

    // stall: four stored, fifth dropped, then drain in order
    ready_cmd = 1'b0;
    do_reset();
    mask = 4'b1111; budget = 4; exp_limit = 4;
    repeat (8) cycle();
    check("t3_full_valid", 32'(evt_valid), 1);
    check("t3_ovf_before", 32'(overflow),  0);
    budget = 1;
    repeat (4) cycle();
    check("t3_ovf_after", 32'(overflow), 1);
    ready_cmd = 1'b1;
    repeat (8) cycle();
    check("t3_drained",   pops_main,        4);
    check("t3_q_empty",   q_main.size(),    0);
    check("t3_valid_low", 32'(evt_valid),   0);

    // full with a pop in the same cycle as the push
    ready_cmd = 1'b0;
    do_reset();
    mask = 4'b1111; budget = 4; exp_limit = -1;
    repeat (8) cycle();
    check("t4_ovf_full", 32'(overflow), 0);
    budget = 1;
    cycle();
    ready_cmd = 1'b1;
    cycle();
    ready_cmd = 1'b0;
    cycle();
    repeat (3) cycle();
    check("t4_ovf_pushpop", 32'(overflow), 0);
    check("t4_one_pop",     pops_main,     1);
    ready_cmd = 1'b1;
    repeat (8) cycle();
    check("t4_occupancy", pops_main - 1, 4);
    check("t4_q_empty",   q_main.size(), 0);

    // idle bus: EMIT_ALL=1 emits every slot, EMIT_ALL=0 emits nothing
    ready_cmd = 1'b1;
    do_reset();
    mask = 4'b0000; budget = -1; all_en = 1;
    saw_valid = 0;
    repeat (20) begin
      cycle();
      if (evt_valid) saw_valid = 1;
    end
    all_en = 0;
    check("t5_all_events", 32'(log_all.size() >= 16), 1);
    mism = 0;
    for (int i = 0; i < log_all.size() && i < 16; i++)
      if (log_all[i] != seq[i]) mism++;
    check("t5_all_seq_mism", mism, 0);
    check("t5_emit0_valid",  32'(saw_valid), 0);

    // asynchronous reset in the low phase, away from any edge
    ready_cmd = 1'b0;
    do_reset();
    mask = 4'b1111; exp_limit = 4;
    repeat (12) cycle();
    check("t6_pre_ovf", 32'(overflow), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid",    32'(evt_valid), 0);
    check("t6_ch",       32'(evt_ch),    0);
    check("t6_data",     32'(evt_data),  0);
    check("t6_gray",     32'(gray_cnt),  0);
    check("t6_overflow", 32'(overflow),  0);
    ready_cmd = 1'b1; exp_limit = -1;
    do_reset();
    mask = 4'b0001;
    repeat (24) cycle();
    mask = 4'b0000;
    repeat (6) cycle();
    check("t6_rerun_events", pops_main,     12);
    check("t6_rerun_q",      q_main.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_demux_rx.md
Name: ro_demux_rx

Overview:
- Off-chip/FPGA-side receiver for the time-multiplexed cochlea readout bus.
- The chip's gray counter gives each gray bit k one bus slot every 2^(k+1) master cycles, during which channel k drives the eve/pol_eve lines.
- This block replicates that counter, decodes which channel owns each slot and captures the two lines.
- It pushes the resulting channel-tagged events into a small FIFO with a valid/ready output.

Parameters:
- N_CH, 19, number of readout channels = chip gray counter width
- CH_W, 5, width of channel index (≥ clog2(N_CH))
- FIFO_DEPTH, 4, event FIFO entries (power of 2)
- EMIT_ALL, 0, 1 = enqueue every slot; 0 = enqueue only slots with ro_eve=1

Ports:
- clk_master  in  1  master clock, same as the chip gray counter clock
- reset  in  1  asynchronous, active-high reset
- sync  in  1  synchronous clear of the replica counter; asserted in the same cycle the chip counter is reset
- ro_eve  in  1  shared readout line, event bit (board pull-down when undriven)
- ro_pol_eve  in  1  shared readout line, polarity bit
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  downstream accepts head on posedge when evt_valid & evt_ready
- evt_ch  out  CH_W  channel index of head event
- evt_data  out  2  {pol_eve, eve} of head event
- gray_cnt  out  N_CH  replica gray count, for debug
- overflow  out  1  sticky; set when an enqueue is dropped because FIFO is full

Behaviour:
- Reset (async, active-high): bin_cnt=0, capture regs=0, FIFO empty, evt_valid=0, evt_ch=0, evt_data=0, overflow=0, gray_cnt=0.
- Counter:
  - bin_cnt increments on every posedge clk_master and wraps 2^N_CH-1→0.
  - gray_cnt = bin_cnt ^ (bin_cnt>>1), registered.
  - sync=1 loads bin_cnt=0 at the posedge; the increment is suppressed that cycle.
- Slot decode:
  - After the posedge that moves the count to c, slot = ctz(c) (number of trailing zeros).
  - c=0, the wrap case, gives slot = N_CH-1.
  - Exactly one slot is active per cycle.
  - slot_valid=0 in the first cycle after reset or sync, since no chip edge has occurred yet.
- Capture:
  - The chip drives the bus only while clk_master is high after the gray edge.
  - On negedge clk_master, register ro_eve, ro_pol_eve, slot and slot_valid into the capture stage. This is the only negedge stage.
- Enqueue:
  - At the next posedge, push {slot, pol, eve} when slot_valid & (EMIT_ALL | eve).
  - Latency: the bus-high phase in cycle t gives evt_valid=1 at the posedge ending cycle t+1, FIFO empty case.
- FIFO:
  - FIFO_DEPTH entries, first-word fall-through; evt_ch and evt_data show the head.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - If full and a push arrives without a pop, drop the new event and set overflow.
  - When full with a simultaneous pop, the push is accepted.
  - Empty: evt_valid=0 and evt_ch/evt_data hold their last value.
- overflow clears only on reset; sync does not clear it.
- A sync in mid-stream does not flush the FIFO. The capture stage gathered in the cycle of sync is still enqueued.
- A reset mid-operation discards all pending events immediately.

Decomposition:
- Shared package ro_pkg: N_CH, CH_W, the event-word type {ch[CH_W-1:0], pol, eve}, and a ctz function returning the slot index with the wrap rule.
- Sub-module ro_evt_fifo: parameterised synchronous FIFO with async active-high reset, first-word fall-through, full/empty, and drop-on-full flag.
- The top holds the counter, decode, capture and enqueue logic.

Test Plan (N_CH=4, CH_W=2, FIFO_DEPTH=4 unless stated):
1. Reset, then sync, then a behavioural chip model (gray counter + slot drivers) drives ro_eve=1 only for channel 0, evt_ready=1 → events every 2 cycles, all with evt_ch=0, evt_data=2'b01 or 2'b11 per the driven pol; no other channels appear.
2. Model drives ro_eve=1 for all channels across 16 cycles → per 16-cycle period, exactly 8 ch0, 4 ch1, 2 ch2 and 2 ch3 events (wrap slot counts as ch3); order matches the ctz sequence 0,1,0,2,0,1,0,3…
3. evt_ready=0 with all channels active → 4 events stored, then overflow=1 on the 5th push. Raising evt_ready drains exactly 4 events in order.
4. FIFO full, evt_ready=1 in the same cycle as a push → no overflow, occupancy stays 4.
5. EMIT_ALL=1 with the bus idle (pull-down 0) → one event per cycle with evt_data=2'b00 and slot sequence per test 2. EMIT_ALL=0 with the same stimulus → evt_valid stays 0.
6. Assert reset asynchronously mid-stream (not on a clock edge) → evt_valid, evt_ch, evt_data, gray_cnt and overflow go to 0 immediately. After reset release plus sync, test 1 passes again.
